mips_id_ex_hazard: RTL and testbench
====================================

MIPS_ID_EX_HAZARD -- requirements
Module: mips_id_ex_hazard

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 Parameter NREG, default 32, register-file depth; register 0 is hard-wired to zero.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cmdD  input  32  instruction in the decode stage.
REQ-006 PCPlusFourD  input  32  PC+4 of the decode instruction.
REQ-007 RegWriteW / WriteRegW / ResultW  input  1/5/32  writeback enable, destination and data.
REQ-008 StallF, StallD  output  1  hold the PC and the IF/ID register.
REQ-009 PCSrcD  output  1  taken branch; PCBranchD  output  32  branch target.
REQ-010 RegWriteM, MemtoRegM, MemWriteM  output  1  EX/MEM control bits.
REQ-011 WriteRegM  output  5; ALUOutM  output  32; WriteDataM  output  32 (EX/MEM register contents).

Function
REQ-012 Decode SHALL support opcode 000000 (R-type), lw 100011, sw 101011, beq 000100 and addi 001000; any other opcode SHALL decode as a NOP with all write and branch controls at 0.
REQ-013 R-type funct SHALL map to ALUControl as: add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111, sll 000000->100.
REQ-014 lw, sw and addi SHALL use ALU add with the sign-extended immediate; beq SHALL set BranchD only.
REQ-015 RegDst SHALL be Rd for R-type and Rt otherwise; MemtoReg SHALL be set for lw only; MemWrite SHALL be set for sw only.
REQ-016 Register-file reads SHALL be combinational with write-through: a read of WriteRegW while RegWriteW=1 (WriteRegW!=0) SHALL return ResultW.
REQ-017 The register-file write SHALL occur on the rising edge when RegWriteW=1 and WriteRegW!=0.
REQ-018 Branch comparison SHALL use operand A = ForwardAD ? ALUOutM : RD1, and operand B likewise with ForwardBD.
REQ-019 PCSrcD SHALL equal BranchD AND (A==B), combinationally.
REQ-020 PCBranchD SHALL equal (SignImm<<2)+PCPlusFourD, modulo 2^32.
REQ-021 ID/EX register SHALL capture controls, RD1, RD2, Rs, Rt, Rd, shamt and SignImm each edge.
REQ-022 When FlushE=1, the ID/EX register SHALL instead load RegWrite=MemtoReg=MemWrite=0 and zero register fields.
REQ-023 SrcAE SHALL be ResultW when ForwardAE=01, ALUOutM when ForwardAE=10, and RD1E otherwise.
REQ-024 SrcBE SHALL be selected the same way by ForwardBE; the forwarded value SHALL be WriteDataE.
REQ-025 The ALU B operand SHALL be SignImmE when ALUSrc=1.
REQ-026 sll SHALL compute RtE-value<<shamtE.
REQ-027 slt SHALL be a signed compare producing 1 or 0; add and sub SHALL wrap modulo 2^32.
REQ-028 WriteRegE SHALL be RdE when RegDst=1, else RtE.
REQ-029 The EX/MEM register SHALL capture controls, ALUOut, WriteDataE and WriteRegE every edge, so results appear 2 edges after decode.
REQ-030 ForwardAE SHALL be 10 if RsE!=0 && RegWriteM && WriteRegM==RsE; else 01 if RsE!=0 && RegWriteW && WriteRegW==RsE; else 00.
REQ-031 ForwardBE SHALL follow the same rule using RtE.
REQ-032 ForwardAD SHALL be RsD!=0 && RegWriteM && WriteRegM==RsD; ForwardBD SHALL follow the same rule using RtD.
REQ-033 lwstall SHALL be MemtoRegE && (RtE==RsD || RtE==RtD).
REQ-034 branchstall SHALL be BranchD && ((RegWriteE && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM in {RsD,RtD})).
REQ-035 StallF, StallD and FlushE SHALL each equal lwstall OR branchstall.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear the ID/EX and EX/MEM registers and all 32 register-file entries to 0.
REQ-037 During reset, StallF=StallD=PCSrcD=0 and all M-stage outputs SHALL read 0.

Structure
REQ-038 Opcode, funct and ALUControl encodings SHALL reside in a shared package mips_pkg.
REQ-039 The hazard/forwarding logic SHALL be the single sub-module mips_hazard_unit (purely combinational); the register file, decode and ALU SHALL be inline.

Verification
REQ-040 Reset, then addi $1,$0,5 -> ALUOutM=5, WriteRegM=1, RegWriteM=1 two edges after decode.
REQ-041 add $2,$1,$1 directly after addi $1=5 -> ForwardAE=ForwardBE=10, ALUOutM=10.
REQ-042 lw $3,0($0) followed by add $4,$3,$3 -> StallF=StallD=FlushE=1 for exactly one cycle; bubble has RegWriteM=0.
REQ-043 beq $1,$1,+3 at PCPlusFourD=0x10 with $1 settled -> PCSrcD=1, PCBranchD=0x1C; beq $1,$2 with unequal values -> PCSrcD=0.
REQ-044 sub $5,$0,$1 with $1=5, then slt $6,$5,$0 -> ALUOutM=0xFFFFFFFB, then ALUOutM=1.
REQ-045 addi $0,$0,7, then add $7,$0,$0 -> ALUOutM=0 and no forwarding from register 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and pipeline-register layouts for the MIPS ID/EX/MEM slice.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLL = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // Operand source for the EX-stage ALU inputs
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      alu_src;
        logic      reg_dst;
        logic      branch;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_dst;
        alu_ctrl_e           alu_ctrl;
        logic [XLEN-1:0]     rd1;
        logic [XLEN-1:0]     rd2;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [REG_AW-1:0]   rd;
        logic [4:0]          shamt;
        logic [XLEN-1:0]     sign_imm;
    } id_ex_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic [XLEN-1:0]     alu_out;
        logic [XLEN-1:0]     write_data;
        logic [REG_AW-1:0]   write_reg;
    } ex_mem_t;

    // Unknown funct codes fall back to add so the ALU output is well defined.
    function automatic alu_ctrl_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            F_ADD:   return ALU_ADD;
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_SLT:   return ALU_SLT;
            F_SLL:   return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

    // Main decoder; unsupported opcodes leave every write/branch control low.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_ctrl  = funct_to_alu(funct);
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_id_ex_hazard_if.sv
// Boundary of the ID/EX/MEM slice: decode instruction in, writeback in,
// stall/branch controls and the EX/MEM register contents out.
interface mips_id_ex_hazard_if;

    logic [31:0] cmdD;
    logic [31:0] PCPlusFourD;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;

    // Fetch/writeback side that feeds the slice
    modport master (
        output cmdD, PCPlusFourD, RegWriteW, WriteRegW, ResultW,
        input  StallF, StallD, PCSrcD, PCBranchD,
               RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUOutM, WriteDataM
    );

    // The slice itself
    modport slave (
        input  cmdD, PCPlusFourD, RegWriteW, WriteRegW, ResultW,
        output StallF, StallD, PCSrcD, PCBranchD,
               RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUOutM, WriteDataM
    );

endinterface

// File: rtl/mips_hazard_unit.sv
// Forwarding selects and stall/flush generation for the 5-stage pipeline.
// Purely combinational.
module mips_hazard_unit
    import mips_pkg::*;
(
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic       reg_write_e,
    input  logic       mem_to_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_m,
    input  logic       mem_to_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_w,
    output fwd_sel_e   forward_ae,
    output fwd_sel_e   forward_be,
    output logic       forward_ad,
    output logic       forward_bd,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_e
);

    logic lw_stall;
    logic branch_stall;
    logic stall;

    // EX-operand forwarding: the younger M-stage result wins over W
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        forward_ae = FWD_NONE;
        forward_be = FWD_NONE;
        if (rs_e != 5'd0 && reg_write_m && write_reg_m == rs_e)
            forward_ae = FWD_M;
        else if (rs_e != 5'd0 && reg_write_w && write_reg_w == rs_e)
            forward_ae = FWD_W;
        if (rt_e != 5'd0 && reg_write_m && write_reg_m == rt_e)
            forward_be = FWD_M;
        else if (rt_e != 5'd0 && reg_write_w && write_reg_w == rt_e)
            forward_be = FWD_W;
    end

    // Decode-stage branch comparator may take the M-stage ALU result
    assign forward_ad = (rs_d != 5'd0) && reg_write_m && (write_reg_m == rs_d);
    assign forward_bd = (rt_d != 5'd0) && reg_write_m && (write_reg_m == rt_d);

    // Load-use and branch-operand-not-ready stalls
    assign lw_stall     = mem_to_reg_e && (rt_e == rs_d || rt_e == rt_d);
    assign branch_stall = branch_d &&
                          ((reg_write_e  && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                           (mem_to_reg_m && (write_reg_m == rs_d || write_reg_m == rt_d)));
    assign stall        = lw_stall || branch_stall;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

endmodule

// File: rtl/mips_id_ex_hazard.sv
// Decode, execute and EX/MEM stages of a classic 5-stage MIPS pipeline,
// with register file, early branch resolution and hazard handling.
module mips_id_ex_hazard
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_id_ex_hazard_if.slave     bus
);

    // ---------------- Decode stage ----------------
    logic [5:0]  op_d;
    logic [5:0]  funct_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic [4:0]  shamt_d;
    logic [31:0] sign_imm_d;
    ctrl_t       ctrl_d;

    assign op_d       = bus.cmdD[31:26];
    assign rs_d       = bus.cmdD[25:21];
    assign rt_d       = bus.cmdD[20:16];
    assign rd_d       = bus.cmdD[15:11];
    assign shamt_d    = bus.cmdD[10:6];
    assign funct_d    = bus.cmdD[5:0];
    assign sign_imm_d = {{16{bus.cmdD[15]}}, bus.cmdD[15:0]};
    assign ctrl_d     = decode(op_d, funct_d);

    logic [DATA_W-1:0] regs [NREG];
    logic [31:0]       rd1_d;
    logic [31:0]       rd2_d;
    logic              wb_en;

    assign wb_en = bus.RegWriteW && (bus.WriteRegW != 5'd0);

    // Register file write port; $0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is cleared on reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            regs[bus.WriteRegW] <= bus.ResultW;
        end
    end

    // Read ports: $0 reads zero, a same-cycle writeback is passed straight through
    always_comb begin
        rd1_d = regs[rs_d];
        rd2_d = regs[rt_d];
        if (rs_d == 5'd0)
            rd1_d = '0;
        else if (wb_en && bus.WriteRegW == rs_d)
            rd1_d = bus.ResultW;
        if (rt_d == 5'd0)
            rd2_d = '0;
        else if (wb_en && bus.WriteRegW == rt_d)
            rd2_d = bus.ResultW;
    end

    // ---------------- Hazard unit ----------------
    id_ex_t   id_ex;
    ex_mem_t  ex_mem;
    logic [4:0] write_reg_e;
    fwd_sel_e forward_ae;
    fwd_sel_e forward_be;
    logic     forward_ad;
    logic     forward_bd;
    logic     stall_f;
    logic     stall_d;
    logic     flush_e;

    mips_hazard_unit u_hazard (
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .branch_d     (ctrl_d.branch),
        .rs_e         (id_ex.rs),
        .rt_e         (id_ex.rt),
        .write_reg_e  (write_reg_e),
        .reg_write_e  (id_ex.reg_write),
        .mem_to_reg_e (id_ex.mem_to_reg),
        .write_reg_m  (ex_mem.write_reg),
        .reg_write_m  (ex_mem.reg_write),
        .mem_to_reg_m (ex_mem.mem_to_reg),
        .write_reg_w  (bus.WriteRegW),
        .reg_write_w  (bus.RegWriteW),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e)
    );

    // ---------------- Early branch resolution ----------------
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;

    assign cmp_a = forward_ad ? ex_mem.alu_out : rd1_d;
    assign cmp_b = forward_bd ? ex_mem.alu_out : rd2_d;

    assign bus.PCSrcD    = rst_n && ctrl_d.branch && (cmp_a == cmp_b);
    assign bus.PCBranchD = {sign_imm_d[29:0], 2'b00} + bus.PCPlusFourD;
    assign bus.StallF    = rst_n && stall_f;
    assign bus.StallD    = rst_n && stall_d;

    // ---------------- ID/EX register ----------------
    id_ex_t id_ex_next;

    always_comb begin
        id_ex_next            = '0;
        id_ex_next.reg_write  = ctrl_d.reg_write;
        id_ex_next.mem_to_reg = ctrl_d.mem_to_reg;
        id_ex_next.mem_write  = ctrl_d.mem_write;
        id_ex_next.alu_src    = ctrl_d.alu_src;
        id_ex_next.reg_dst    = ctrl_d.reg_dst;
        id_ex_next.alu_ctrl   = ctrl_d.alu_ctrl;
        id_ex_next.rd1        = rd1_d;
        id_ex_next.rd2        = rd2_d;
        id_ex_next.rs         = rs_d;
        id_ex_next.rt         = rt_d;
        id_ex_next.rd         = rd_d;
        id_ex_next.shamt      = shamt_d;
        id_ex_next.sign_imm   = sign_imm_d;
    end

    // Capture decode results each edge; a flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            id_ex <= '0;
        else if (flush_e)
            id_ex <= '0;
        else
            id_ex <= id_ex_next;
    end

    // ---------------- Execute stage ----------------
    logic [31:0] src_a;
    logic [31:0] write_data_e;
    logic [31:0] src_b;
    logic [31:0] alu_out_e;

    assign write_reg_e = id_ex.reg_dst ? id_ex.rd : id_ex.rt;

    // Operand forwarding muxes
    always_comb begin
        src_a        = id_ex.rd1;
        write_data_e = id_ex.rd2;
        case (forward_ae)
            FWD_M:   src_a = ex_mem.alu_out;
            FWD_W:   src_a = bus.ResultW;
            default: ;
        endcase
        case (forward_be)
            FWD_M:   write_data_e = ex_mem.alu_out;
            FWD_W:   write_data_e = bus.ResultW;
            default: ;
        endcase
    end

    assign src_b = id_ex.alu_src ? id_ex.sign_imm : write_data_e;

    // ALU; sll shifts the (forwarded) Rt value by the instruction's shamt
    always_comb begin
        alu_out_e = '0;
        case (id_ex.alu_ctrl)
            ALU_ADD: alu_out_e = src_a + src_b;
            ALU_SUB: alu_out_e = src_a - src_b;
            ALU_AND: alu_out_e = src_a & src_b;
            ALU_OR:  alu_out_e = src_a | src_b;
            ALU_SLT: alu_out_e = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLL: alu_out_e = write_data_e << id_ex.shamt;
            default: alu_out_e = '0;
        endcase
    end

    // ---------------- EX/MEM register ----------------
    // Capture EX results every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem <= '0;
        end else begin
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_to_reg <= id_ex.mem_to_reg;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.alu_out    <= alu_out_e;
            ex_mem.write_data <= write_data_e;
            ex_mem.write_reg  <= write_reg_e;
        end
    end

    assign bus.RegWriteM  = ex_mem.reg_write;
    assign bus.MemtoRegM  = ex_mem.mem_to_reg;
    assign bus.MemWriteM  = ex_mem.mem_write;
    assign bus.WriteRegM  = ex_mem.write_reg;
    assign bus.ALUOutM    = ex_mem.alu_out;
    assign bus.WriteDataM = ex_mem.write_data;

endmodule

// File: tb/tb_mips_id_ex_hazard.sv
// Directed bench for mips_id_ex_hazard. The bench plays the IF/ID register
// (drives cmdD, holds it on a stall) and the MEM/WB register (feeds the
// M-stage result back as the writeback inputs one edge later).
module tb_mips_id_ex_hazard;
    import mips_pkg::*;

    localparam logic [31:0] LW_DATA = 32'd9;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mips_id_ex_hazard_if bus ();

    mips_id_ex_hazard #(.DATA_W(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] f);
        return {OP_RTYPE, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Present an instruction in decode and let combinational logic settle
    task automatic issue(input logic [31:0] cmd, input logic [31:0] pc4);
        bus.cmdD        = cmd;
        bus.PCPlusFourD = pc4;
        #1;
    endtask

    // One clock edge, with the MEM/WB register modelled around it
    task automatic tick();
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        rw  = bus.RegWriteM;
        wr  = bus.WriteRegM;
        res = bus.MemtoRegM ? LW_DATA : bus.ALUOutM;
        @(posedge clk);
        #1;
        bus.RegWriteW = rw;
        bus.WriteRegW = wr;
        bus.ResultW   = res;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.RegWriteW   = 1'b0;
        bus.WriteRegW   = 5'd0;
        bus.ResultW     = 32'd0;
        bus.cmdD        = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd1);
        bus.PCPlusFourD = 32'd0;

        // Reset: outputs quiet even with a taken beq in decode
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_stallf", 32'(bus.StallF), 32'd0);
        check("rst_stalld", 32'(bus.StallD), 32'd0);
        check("rst_pcsrc", 32'(bus.PCSrcD), 32'd0);
        check("rst_regwm", 32'(bus.RegWriteM), 32'd0);
        check("rst_aluout", bus.ALUOutM, 32'd0);
        check("rst_wregm", 32'(bus.WriteRegM), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi $1,$0,5 then add $2,$1,$1
        issue(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5), 32'h4);
        tick();
        issue(enc_r(5'd1, 5'd1, 5'd2, 5'd0, F_ADD), 32'h8);
        tick();
        check("addi_aluout", bus.ALUOutM, 32'd5);
        check("addi_wregm", 32'(bus.WriteRegM), 32'd1);
        check("addi_regwm", 32'(bus.RegWriteM), 32'd1);

        // lw $3,0($0); add $2 now in EX, forwarded twice from M
        issue(enc_i(OP_LW, 5'd0, 5'd3, 16'd0), 32'hC);
        check("add2_fwd_ae", 32'(dut.forward_ae), 32'h2);
        check("add2_fwd_be", 32'(dut.forward_be), 32'h2);
        tick();
        check("add2_aluout", bus.ALUOutM, 32'd10);
        check("add2_wregm", 32'(bus.WriteRegM), 32'd2);

        // add $4,$3,$3 behind the load: one stall cycle
        issue(enc_r(5'd3, 5'd3, 5'd4, 5'd0, F_ADD), 32'h10);
        check("lu_stallf", 32'(bus.StallF), 32'd1);
        check("lu_stalld", 32'(bus.StallD), 32'd1);
        check("lu_flushe", 32'(dut.flush_e), 32'd1);
        tick();
        issue(enc_r(5'd3, 5'd3, 5'd4, 5'd0, F_ADD), 32'h10);
        check("lu_stallf_rel", 32'(bus.StallF), 32'd0);
        check("lu_flushe_rel", 32'(dut.flush_e), 32'd0);
        check("lw_memtoregm", 32'(bus.MemtoRegM), 32'd1);
        tick();
        check("bubble_regwm", 32'(bus.RegWriteM), 32'd0);

        // beq $1,$1,+3 at PC+4=0x10: taken; add $4 in EX takes $3 from W
        issue(enc_i(OP_BEQ, 5'd1, 5'd1, 16'd3), 32'h10);
        check("beq_pcsrc", 32'(bus.PCSrcD), 32'd1);
        check("beq_target", bus.PCBranchD, 32'h1C);
        check("beq_nostall", 32'(bus.StallF), 32'd0);
        check("add4_fwd_ae", 32'(dut.forward_ae), 32'h1);
        tick();
        check("add4_aluout", bus.ALUOutM, 32'd18);
        check("add4_wregm", 32'(bus.WriteRegM), 32'd4);

        // beq $1,$2 with 5 != 10: not taken
        issue(enc_i(OP_BEQ, 5'd1, 5'd2, 16'd3), 32'h14);
        check("beq_ne_pcsrc", 32'(bus.PCSrcD), 32'd0);
        tick();
        check("beq_regwm", 32'(bus.RegWriteM), 32'd0);

        // sub $5,$0,$1 then slt $6,$5,$0
        issue(enc_r(5'd0, 5'd1, 5'd5, 5'd0, F_SUB), 32'h18);
        tick();
        issue(enc_r(5'd5, 5'd0, 5'd6, 5'd0, F_SLT), 32'h1C);
        tick();
        check("sub_aluout", bus.ALUOutM, 32'hFFFF_FFFB);
        check("sub_wregm", 32'(bus.WriteRegM), 32'd5);

        // addi $0,$0,7 then add $7,$0,$0
        issue(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7), 32'h20);
        check("slt_fwd_ae", 32'(dut.forward_ae), 32'h2);
        tick();
        check("slt_aluout", bus.ALUOutM, 32'd1);
        check("slt_wregm", 32'(bus.WriteRegM), 32'd6);
        issue(enc_r(5'd0, 5'd0, 5'd7, 5'd0, F_ADD), 32'h24);
        tick();
        check("addi0_aluout", bus.ALUOutM, 32'd7);
        check("addi0_wregm", 32'(bus.WriteRegM), 32'd0);
        issue(32'd0, 32'h28);
        check("add7_fwd_ae", 32'(dut.forward_ae), 32'h0);
        check("add7_fwd_be", 32'(dut.forward_be), 32'h0);
        tick();
        check("add7_aluout", bus.ALUOutM, 32'd0);
        check("add7_wregm", 32'(bus.WriteRegM), 32'd7);

        // or / and / sll / sw on settled registers ($1=5, $2=10, $4=18)
        issue(enc_r(5'd1, 5'd2, 5'd10, 5'd0, F_OR), 32'h2C);
        tick();
        issue(enc_r(5'd2, 5'd4, 5'd11, 5'd0, F_AND), 32'h30);
        tick();
        check("or_aluout", bus.ALUOutM, 32'd15);
        issue(enc_r(5'd0, 5'd1, 5'd12, 5'd4, F_SLL), 32'h34);
        tick();
        check("and_aluout", bus.ALUOutM, 32'd2);
        issue(enc_i(OP_SW, 5'd0, 5'd1, 16'd4), 32'h38);
        tick();
        check("sll_aluout", bus.ALUOutM, 32'd80);
        issue(enc_i(OP_ADDI, 5'd0, 5'd8, 16'h1234), 32'h3C);
        tick();
        check("sw_aluout", bus.ALUOutM, 32'd4);
        check("sw_memwm", 32'(bus.MemWriteM), 32'd1);
        check("sw_wdatam", bus.WriteDataM, 32'd5);
        check("sw_regwm", 32'(bus.RegWriteM), 32'd0);

        // Write-through: add $9,$8,$0 decoded while $8 is only on the W bus
        issue(32'd0, 32'h40);
        tick();
        issue(32'd0, 32'h44);
        tick();
        issue(enc_r(5'd8, 5'd0, 5'd9, 5'd0, F_ADD), 32'h48);
        tick();
        issue(32'd0, 32'h4C);
        tick();
        check("wt_aluout", bus.ALUOutM, 32'h1234);
        check("wt_wregm", 32'(bus.WriteRegM), 32'd9);

        // Asynchronous reset mid-cycle clears M stage and the register file
        rst_n = 1'b0;
        #1;
        check("arst_aluout", bus.ALUOutM, 32'd0);
        check("arst_regwm", 32'(bus.RegWriteM), 32'd0);
        bus.RegWriteW = 1'b0;
        bus.WriteRegW = 5'd0;
        bus.ResultW   = 32'd0;
        issue(enc_i(OP_BEQ, 5'd1, 5'd0, 16'hFFFF), 32'h100);
        check("arst_pcsrc", 32'(bus.PCSrcD), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("clr_pcsrc", 32'(bus.PCSrcD), 32'd1);
        check("neg_target", bus.PCBranchD, 32'hFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
